// File: rtl/note_display_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | note_display_arbiter                                                        |
// | Frame-synchronous arbiter sharing the one-hot VGA colour select between     |
// | keyboard, autoplay and learn-mode note sources.                             |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module note_display_arbiter #(
  parameter int HOLD_FRAMES = 6,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       kbd_valid,
  input  logic [2:0] kbd_note,
  output logic       kbd_ready,
  input  logic       auto_valid,
  input  logic [2:0] auto_note,
  output logic       auto_ready,
  input  logic       learn_valid,
  input  logic [2:0] learn_note,
  output logic       learn_ready,
  output logic [6:0] color_sel,
  output logic [1:0] owner,
  output logic       busy
);

  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

  localparam logic [1:0]       OWN_NONE    = 2'd0;
  localparam logic [1:0]       OWN_KBD     = 2'd1;
  localparam logic [1:0]       OWN_AUTO    = 2'd2;
  localparam logic [1:0]       OWN_LEARN   = 2'd3;
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_FRAMES - 1);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic             rr_ptr;
  logic             open;
  logic [1:0]       winner;
  logic [1:0]       grant;
  logic [2:0]       grant_note;

  // Note n lights bit (7-n); rest (0) is black.
  function automatic logic [6:0] note_to_color(input logic [2:0] note);
    logic [6:0] c;
    c = '0;
    if (note != 3'd0) c[3'd7 - note] = 1'b1;
    return c;
  endfunction

  always_comb begin
    // A slot may be (re)granted when idle, on keyboard preemption, or once the hold expires.
    open = frame_tick & ~rst &
           ((state == IDLE) | (kbd_valid & (owner != OWN_KBD)) | (hold_cnt == '0));

    winner = OWN_NONE;
    if (kbd_valid)                    winner = OWN_KBD;
    else if (auto_valid & learn_valid) winner = rr_ptr ? OWN_LEARN : OWN_AUTO;
    else if (auto_valid)              winner = OWN_AUTO;
    else if (learn_valid)             winner = OWN_LEARN;

    grant = open ? winner : OWN_NONE;

    case (grant)
      OWN_KBD:   grant_note = kbd_note;
      OWN_AUTO:  grant_note = auto_note;
      OWN_LEARN: grant_note = learn_note;
      default:   grant_note = 3'd0;
    endcase
  end

  assign kbd_ready   = (grant == OWN_KBD);
  assign auto_ready  = (grant == OWN_AUTO);
  assign learn_ready = (grant == OWN_LEARN);
  assign busy        = (state == SHOW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      color_sel <= '0;
      owner     <= OWN_NONE;
      hold_cnt  <= '0;
      rr_ptr    <= 1'b0;
    end else if (frame_tick) begin
      if (grant != OWN_NONE) begin
        state     <= SHOW;
        owner     <= grant;
        color_sel <= note_to_color(grant_note);
        hold_cnt  <= HOLD_RELOAD;
        if (grant == OWN_AUTO)       rr_ptr <= 1'b1;
        else if (grant == OWN_LEARN) rr_ptr <= 1'b0;
      end else if (state == SHOW) begin
        if (hold_cnt != '0) begin
          hold_cnt <= hold_cnt - 1'b1;
        end else begin
          state     <= IDLE;
          color_sel <= '0;
          owner     <= OWN_NONE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_note_display_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_note_display_arbiter                                                     |
// | Scoreboard bench: directed scenarios plus randomized requesters.            |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_note_display_arbiter;

  localparam int HOLD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       kbd_valid = 1'b0, auto_valid = 1'b0, learn_valid = 1'b0;
  logic [2:0] kbd_note = '0, auto_note = '0, learn_note = '0;
  logic       kbd_ready, auto_ready, learn_ready;
  logic [6:0] color_sel;
  logic [1:0] owner;
  logic       busy;

  always #5 clk = ~clk;

  note_display_arbiter #(.HOLD_FRAMES(HOLD), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .kbd_valid(kbd_valid), .kbd_note(kbd_note), .kbd_ready(kbd_ready),
    .auto_valid(auto_valid), .auto_note(auto_note), .auto_ready(auto_ready),
    .learn_valid(learn_valid), .learn_note(learn_note), .learn_ready(learn_ready),
    .color_sel(color_sel), .owner(owner), .busy(busy)
  );

  // Colour palette indexed by note: rest, red, orange, yellow, green, cyan, blue, purple.
  logic [6:0] palette [0:7] = '{7'b0000000, 7'b1000000, 7'b0100000, 7'b0010000,
                                7'b0001000, 7'b0000100, 7'b0000010, 7'b0000001};

  typedef struct {
    int         who;
    logic [6:0] color;
    int         own;
    int         bsy;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Requester intent (index 1 kbd, 2 auto, 3 learn) and model of the display slot.
  bit       rv [1:3];
  int       rn [1:3];
  bit [3:1] keep;
  int       m_owner, m_note, m_age, m_rr;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    if (rv[1]) return 1;
    if (rv[2] && rv[3]) return (m_rr != 0) ? 3 : 2;
    if (rv[2]) return 2;
    if (rv[3]) return 3;
    return 0;
  endfunction

  task automatic apply(input bit tick, input bit r);
    exp_t e;
    int   who;
    for (int i = 1; i <= 3; i++) if (keep[i]) rv[i] = 1'b1;
    rst = r;
    frame_tick = tick;
    kbd_valid = rv[1];   kbd_note = 3'(rn[1]);
    auto_valid = rv[2];  auto_note = 3'(rn[2]);
    learn_valid = rv[3]; learn_note = 3'(rn[3]);
    who = 0;
    if (r) begin
      m_owner = 0; m_age = 0; m_rr = 0;
    end else if (tick) begin
      if (m_owner != 0 && rv[1] && m_owner != 1) who = 1;
      else if (m_owner != 0 && m_age + 1 < HOLD) m_age++;
      else begin
        who = pick();
        if (who == 0) m_owner = 0;
      end
      if (who != 0) begin
        m_owner = who; m_note = rn[who]; m_age = 0;
        if (who == 2) m_rr = 1;
        if (who == 3) m_rr = 0;
      end
    end
    if (tick) begin
      e.who   = who;
      e.own   = m_owner;
      e.bsy   = (m_owner != 0) ? 1 : 0;
      e.color = (m_owner != 0) ? palette[m_note] : 7'b0;
      q.push_back(e);
    end
    if (who != 0) rv[who] = 1'b0;
  endtask

  task automatic cyc(input bit tick, input bit r = 1'b0);
    @(posedge clk);
    #1;
    apply(tick, r);
  endtask

  task automatic frames(input int n, input int period);
    for (int f = 0; f < n; f++)
      for (int c = 0; c < period; c++) cyc(c == period - 1);
  endtask

  // Monitor: pops one expectation per presented frame_tick and tracks display outputs.
  logic [6:0] exp_col = '0;
  int         exp_own = 0, exp_bsy = 0;

  always @(negedge clk) begin
    exp_t e;
    int   got, nrdy;
    nrdy = int'(kbd_ready) + int'(auto_ready) + int'(learn_ready);
    got  = kbd_ready ? 1 : auto_ready ? 2 : learn_ready ? 3 : 0;
    if (rst) begin
      exp_col = '0; exp_own = 0; exp_bsy = 0;
    end
    chk("color_sel", int'(color_sel), int'(exp_col));
    chk("owner", int'(owner), exp_own);
    chk("busy", int'(busy), exp_bsy);
    chk("ready_onehot", (nrdy <= 1) ? 1 : 0, 1);
    if (frame_tick) begin
      if (q.size() == 0) begin
        chk("scoreboard_underflow", q.size(), 1);
      end else begin
        e = q.pop_front();
        chk("grant", got, e.who);
        exp_col = e.color; exp_own = e.own; exp_bsy = e.bsy;
      end
    end else begin
      chk("ready_off_tick", got, 0);
    end
  end

  initial begin
    for (int i = 1; i <= 3; i++) begin rv[i] = 0; rn[i] = 0; end
    keep = '0;
    m_owner = 0; m_note = 0; m_age = 0; m_rr = 0;
    rst = 1'b1;
    repeat (3) cyc(1'b0, 1'b1);
    cyc(1'b0);

    // Single auto note 3 shown for HOLD frames then black.
    rv[2] = 1; rn[2] = 3;
    frames(HOLD + 2, 4);

    // Off-tick keyboard request withdrawn before the tick.
    rv[1] = 1; rn[1] = 2;
    cyc(0); cyc(0);
    rv[1] = 0;
    cyc(0); cyc(1);

    // Rest note from keyboard occupies a slot.
    rv[1] = 1; rn[1] = 0;
    frames(HOLD + 1, 3);

    // Round-robin between continuous auto and learn requests.
    rn[2] = 2; rn[3] = 6; keep = 3'b110;
    frames(4 * HOLD, 2);
    keep = '0; rv[2] = 0; rv[3] = 0;
    frames(HOLD + 1, 2);

    // Learn note 5 preempted by keyboard note 1; waiting auto cannot preempt.
    rv[3] = 1; rn[3] = 5;
    frames(1, 3);
    rv[1] = 1; rn[1] = 1; rv[2] = 1; rn[2] = 4;
    frames(HOLD + 3, 3);

    // Asynchronous reset mid-show with a pending handshake.
    rv[1] = 1; rn[1] = 4;
    frames(2, 3);
    rv[2] = 1; rn[2] = 7;
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    frames(HOLD + 2, 3);

    // Randomized requesters with random frame lengths.
    for (int f = 0; f < 300; f++) begin
      int period;
      period = $urandom_range(2, 5);
      for (int c = 0; c < period; c++) begin
        for (int i = 1; i <= 3; i++) begin
          if (!rv[i] && $urandom_range(0, (i == 1) ? 11 : 3) == 0) begin
            rv[i] = 1; rn[i] = $urandom_range(0, 7);
          end else if (rv[i] && $urandom_range(0, 19) == 0) begin
            rv[i] = 0;
          end
        end
        cyc(c == period - 1);
      end
    end

    for (int i = 1; i <= 3; i++) rv[i] = 0;
    repeat (3) cyc(0);
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
